// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: controller and two-way round-robin arbiter that time-shares one
// repeated-addition multiplier datapath between two requesters.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req{0,1}_i             level requests; sampled only while idle
//   a{0,1}_i, b{0,1}_i     multiplicand / multiplier (add count) per requester
//   gnt{0,1}_o             one-cycle grant pulse; operands are captured on that edge
//   busy_o                 high whenever a job is in flight
//   done_o                 one-cycle result-valid pulse
//   result_o, result_id_o  last completed product and its owner, held until next done
//   dp_data_o              drives the datapath data_in bus
//   ld_a_o, ld_b_o, clr_p_o, ld_p_o, dec_b_o   datapath strobes
//   eqz_i                  datapath B == 0
//   p_in_i                 datapath P register
module mul_share_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic         req1_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  output logic         gnt0_o,
  output logic         gnt1_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         result_id_o,
  output logic [W-1:0] dp_data_o,
  output logic         ld_a_o,
  output logic         ld_b_o,
  output logic         clr_p_o,
  output logic         ld_p_o,
  output logic         dec_b_o,
  input  logic         eqz_i,
  input  logic [W-1:0] p_in_i
);

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StAccum, StDone} state_e;

  state_e       state_q;
  logic [W-1:0] a_q, b_q, result_q;
  logic         id_q, result_id_q, done_q;
  // Requester favoured when both request: the one not served most recently.
  logic         prio_q;
  logic         gnt0, gnt1;

  always_comb begin
    gnt0 = (state_q == StIdle) && req0_i && (!req1_i || !prio_q);
    gnt1 = (state_q == StIdle) && req1_i && (!req0_i || prio_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      result_q    <= '0;
      result_id_q <= 1'b0;
      done_q      <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt0) begin
            a_q     <= a0_i;
            b_q     <= b0_i;
            id_q    <= 1'b0;
            state_q <= StLoadA;
          end else if (gnt1) begin
            a_q     <= a1_i;
            b_q     <= b1_i;
            id_q    <= 1'b1;
            state_q <= StLoadA;
          end
        end
        StLoadA: state_q <= StLoadB;
        StLoadB: state_q <= StAccum;
        StAccum: begin
          if (eqz_i) begin
            result_q    <= p_in_i;
            result_id_q <= id_q;
            done_q      <= 1'b1;
            prio_q      <= ~id_q;
            state_q     <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Datapath strobes decode purely from state (plus eqz in ACCUM).
  always_comb begin
    dp_data_o = '0;
    ld_a_o    = 1'b0;
    ld_b_o    = 1'b0;
    clr_p_o   = 1'b0;
    ld_p_o    = 1'b0;
    dec_b_o   = 1'b0;
    unique case (state_q)
      StLoadA: begin
        dp_data_o = a_q;
        ld_a_o    = 1'b1;
      end
      StLoadB: begin
        dp_data_o = b_q;
        ld_b_o    = 1'b1;
        clr_p_o   = 1'b1;
      end
      StAccum: begin
        ld_p_o  = !eqz_i;
        dec_b_o = !eqz_i;
      end
      default: ;
    endcase
  end

  assign gnt0_o      = gnt0;
  assign gnt1_o      = gnt1;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_id_o = result_id_q;

endmodule
